// File: rtl/result_accumulator_8_bit.sv
// result_accumulator_8_bit
//
// Sums N_SAMPLES consecutive 8-bit Result words from the add/mul/compare
// stage into one frame total. The total is presented on a registered
// valid/ready port. Upstream is held off (in_ready=0) while a total is
// pending.
//
// Optional feature macro: RESULT_ACC_MAX_EN
//   When defined, the frame maximum is tracked and presented on out_max.
//
// Parameters:
//   N_SAMPLES  results per frame (2..16)
//   ACC_W      accumulator / sum width, >= 8 + ceil(log2(N_SAMPLES))
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_result  unsigned Result word
//   in_valid   in_result valid this cycle
//   in_ready   block accepts a word this cycle
//   clear      synchronous frame abort, highest priority
//   out_sum    frame total, unsigned
//   out_count  samples per frame (constant N_SAMPLES)
//   out_valid  out_sum valid
//   out_ready  downstream accepts out_sum
//   out_max    largest word of the frame (RESULT_ACC_MAX_EN only)

module result_accumulator_8_bit #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_result,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] out_sum,
    output logic [4:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready
`ifdef RESULT_ACC_MAX_EN
    ,
    output logic [7:0]       out_max
`endif
);

    localparam logic       ST_ACCUM = 1'b0;
    localparam logic       ST_HOLD  = 1'b1;
    localparam logic [4:0] LAST_IDX = 5'(N_SAMPLES - 1);

    logic             state;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic             in_fire;
    logic             out_fire;
    logic             last_word;
    logic [ACC_W-1:0] acc_sum;

    // Unsigned maximum of two words.
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Handshake decode is from registered state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign out_count = 5'(N_SAMPLES);

    assign in_fire   = in_valid && (state == ST_ACCUM);
    assign out_fire  = out_ready && (state == ST_HOLD);
    assign last_word = (cnt == LAST_IDX);
    assign acc_sum   = acc + ACC_W'(in_result);

    // Accumulate stage: frame counter, running sum and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACCUM;
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
        end else if (clear) begin
            // Abort wins over any simultaneous input or output transfer.
            // out_sum keeps its old value; it is meaningless once out_valid drops.
            state <= ST_ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else if (in_fire) begin
            if (last_word) begin
                out_sum <= acc_sum;
                acc     <= '0;
                cnt     <= '0;
                state   <= ST_HOLD;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 5'd1;
            end
        end else if (out_fire) begin
            state <= ST_ACCUM;
        end
    end

`ifdef RESULT_ACC_MAX_EN
    logic [7:0] max_reg;

    // Running-max stage, follows the same frame boundaries as the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg <= '0;
            out_max <= '0;
        end else if (clear) begin
            max_reg <= '0;
        end else if (in_fire) begin
            if (last_word) begin
                out_max <= max8(max_reg, in_result);
                max_reg <= '0;
            end else begin
                max_reg <= max8(max_reg, in_result);
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_accumulator_8_bit.sv
module tb_result_accumulator_8_bit;

    localparam int NA = 4;
    localparam int NB = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_result;
    logic          in_valid;
    logic          clear;
    logic          out_ready;

    logic          in_ready_a, out_valid_a;
    logic [AW-1:0] out_sum_a;
    logic [4:0]    out_count_a;
    logic          in_ready_b, out_valid_b;
    logic [AW-1:0] out_sum_b;
    logic [4:0]    out_count_b;
`ifdef RESULT_ACC_MAX_EN
    logic [7:0]    out_max_a, out_max_b;
`endif

    result_accumulator_8_bit #(.N_SAMPLES(NA), .ACC_W(AW)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_result(in_result), .in_valid(in_valid),
        .in_ready(in_ready_a), .clear(clear), .out_sum(out_sum_a),
        .out_count(out_count_a), .out_valid(out_valid_a), .out_ready(out_ready)
`ifdef RESULT_ACC_MAX_EN
        , .out_max(out_max_a)
`endif
    );

    result_accumulator_8_bit #(.N_SAMPLES(NB), .ACC_W(AW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_result(in_result), .in_valid(in_valid),
        .in_ready(in_ready_b), .clear(clear), .out_sum(out_sum_b),
        .out_count(out_count_b), .out_valid(out_valid_b), .out_ready(out_ready)
`ifdef RESULT_ACC_MAX_EN
        , .out_max(out_max_b)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: each instance keeps the words of the current frame in
    // a queue; a full frame yields its sum and max and a pending output.
    int q0[$];
    int q1[$];
    bit m_hold[2];
    int m_sum[2];
    int m_max[2];

    function automatic int sum_q(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    function automatic int max_q(input int q[$]);
        int m = 0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_hold[0] = 1'b0;
        m_hold[1] = 1'b0;
        m_sum[0] = 0; m_sum[1] = 0;
        m_max[0] = 0; m_max[1] = 0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                if (k == 0) q0.delete(); else q1.delete();
                m_hold[k] = 1'b0;
            end else if (!m_hold[k] && in_valid) begin
                if (k == 0) begin
                    q0.push_back(int'(in_result));
                    if (q0.size() == NA) begin
                        m_sum[0] = sum_q(q0); m_max[0] = max_q(q0);
                        q0.delete(); m_hold[0] = 1'b1;
                    end
                end else begin
                    q1.push_back(int'(in_result));
                    if (q1.size() == NB) begin
                        m_sum[1] = sum_q(q1); m_max[1] = max_q(q1);
                        q1.delete(); m_hold[1] = 1'b1;
                    end
                end
            end else if (m_hold[k] && out_ready) begin
                m_hold[k] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k);
        int ir, ov, s, c, n;
        string t;
        if (k == 0) begin
            t = "a"; n = NA;
            ir = int'(in_ready_a); ov = int'(out_valid_a);
            s = int'(out_sum_a); c = int'(out_count_a);
        end else begin
            t = "b"; n = NB;
            ir = int'(in_ready_b); ov = int'(out_valid_b);
            s = int'(out_sum_b); c = int'(out_count_b);
        end
        chk({t, "_in_ready"}, ir, m_hold[k] ? 0 : 1);
        chk({t, "_out_valid"}, ov, m_hold[k] ? 1 : 0);
        chk({t, "_out_count"}, c, n);
        if (m_hold[k]) begin
            chk({t, "_out_sum"}, s, m_sum[k]);
`ifdef RESULT_ACC_MAX_EN
            chk({t, "_out_max"}, (k == 0) ? int'(out_max_a) : int'(out_max_b), m_max[k]);
`endif
        end
    endtask

    task automatic check_all();
        check_dut(0);
        check_dut(1);
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
        in_valid  = v;
        in_result = d;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic word(input logic [7:0] d, input logic ordy);
        drive(1'b1, d, ordy, 1'b0);
        cycle();
    endtask

    task automatic do_clear();
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        cycle();
    endtask

    initial begin
        int nb;
        int guard;
        logic [7:0] w1[4];
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("rst_out_sum_a", int'(out_sum_a), 0);
        chk("rst_in_ready_a", int'(in_ready_a), 1);
`ifdef RESULT_ACC_MAX_EN
        chk("rst_out_max_a", int'(out_max_a), 0);
`endif
        rst_n = 1'b1;

        // Back-to-back frame 10,20,30,40 with out_ready high
        w1 = '{8'd10, 8'd20, 8'd30, 8'd40};
        foreach (w1[i]) word(w1[i], 1'b1);
        chk("t1_model_sum", m_sum[0], 100);
        chk("t1_model_max", m_max[0], 40);
        chk("t1_out_valid", int'(out_valid_a), 1);
        chk("t1_out_sum", int'(out_sum_a), 100);
        chk("t1_out_count", int'(out_count_a), 4);
        chk("t1_in_ready_hold", int'(in_ready_a), 0);
`ifdef RESULT_ACC_MAX_EN
        chk("t1_out_max", int'(out_max_a), 40);
`endif
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cycle();
        chk("t1_in_ready_back", int'(in_ready_a), 1);

        // 4 x 255 held for 5 cycles
        do_clear();
        for (int i = 0; i < 4; i++) word(8'd255, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'd0, 1'b0, 1'b0);
            cycle();
            chk("t2_hold_sum", int'(out_sum_a), 1020);
            chk("t2_hold_in_ready", int'(in_ready_a), 0);
        end
        drive(1'b1, 8'd77, 1'b1, 1'b0);
        cycle();
        chk("t2_after_xfer_in_ready", int'(in_ready_a), 1);

        // Clear coincident with a word discards the partial frame
        do_clear();
        word(8'd5, 1'b0);
        word(8'd7, 1'b0);
        drive(1'b1, 8'd9, 1'b0, 1'b1);
        cycle();
        for (int i = 1; i <= 4; i++) word(8'(i), 1'b0);
        chk("t3_out_sum", int'(out_sum_a), 10);
        chk("t3_out_valid", int'(out_valid_a), 1);

        // Clear during HOLD drops the pending output
        do_clear();
        foreach (w1[i]) word(w1[i], 1'b0);
        chk("t4_hold_sum", int'(out_sum_a), 100);
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        cycle();
        chk("t4_out_valid_dropped", int'(out_valid_a), 0);

        // Asynchronous reset mid-frame after two words
        word(8'd50, 1'b0);
        word(8'd60, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t5_async_out_sum", int'(out_sum_a), 0);
        chk("t5_async_in_ready", int'(in_ready_a), 1);
        chk("t5_async_out_valid", int'(out_valid_a), 0);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) word(8'd1, 1'b0);
        chk("t5_out_sum", int'(out_sum_a), 4);

        // 16 x 255 with gaps on the 16-sample instance
        do_clear();
        nb = 0;
        guard = 0;
        while (nb < 16 && guard < 400) begin
            logic v;
            v = ($urandom_range(0, 2) != 0);
            drive(v, 8'd255, 1'b0, 1'b0);
            cycle();
            if (v) nb++;
            guard++;
        end
        chk("t6_words_sent", nb, 16);
        chk("t6_out_valid", int'(out_valid_b), 1);
        chk("t6_out_sum", int'(out_sum_b), 4080);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 3));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
